calc_nport: RTL

CALC_NPORT -- requirements
Module: calc_nport

---
 rtl/calc_nport.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/calc_nport.sv
// Multi-port two-operand calculator: per-port request capture, round-robin
// arbitration into a shared two-stage compute pipeline, one-cycle responses.
module calc_nport #(
   parameter int WIDTH = 32,
   parameter int PORTS = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [4*PORTS-1:0]     req_cmd,
   input  logic [WIDTH*PORTS-1:0] req_data,
   output logic [2*PORTS-1:0]     out_resp,
   output logic [WIDTH*PORTS-1:0] out_data,
   output logic [PORTS-1:0]       busy
);

   localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam int SW = $clog2(WIDTH);

   logic [PORTS-1:0] busy_q;
   logic [PORTS-1:0] wait_op2_q;
   logic [PORTS-1:0] pend_q;
   logic [PORTS-1:0] resp_v;
   logic [PORTS-1:0] gnt_oh_d;
   logic [3:0]       cmd_q [PORTS];
   logic [WIDTH-1:0] op1_q [PORTS];
   logic [WIDTH-1:0] op2_q [PORTS];
   logic [1:0]       resp_q [PORTS];
   logic [WIDTH-1:0] data_q [PORTS];

   logic [PW-1:0]    ptr_q;
   logic             gnt_valid_d;
   logic [PW-1:0]    gnt_idx_d;

   logic             s1_valid_q;
   logic [PW-1:0]    s1_port_q;
   logic [3:0]       s1_cmd_q;
   logic [WIDTH-1:0] s1_a_q;
   logic [WIDTH-1:0] s1_b_q;

   logic [WIDTH:0]   sum_d;
   logic [1:0]       res_code_d;
   logic [WIDTH-1:0] res_data_d;

   // Round-robin: scan from the pointer; the nearest pending port wins.
   always_comb begin
      int idx;
      gnt_valid_d = 1'b0;
      gnt_idx_d   = '0;
      idx         = 0;
      for (int i = PORTS - 1; i >= 0; i--) begin
         idx = int'(ptr_q) + i;
         if (idx >= PORTS) idx = idx - PORTS;
         if (pend_q[idx[PW-1:0]]) begin
            gnt_valid_d = 1'b1;
            gnt_idx_d   = idx[PW-1:0];
         end
      end
   end

   always_comb begin
      gnt_oh_d = '0;
      if (gnt_valid_d) gnt_oh_d[gnt_idx_d] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_port_q  <= '0;
         s1_cmd_q   <= '0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
      end else begin
         s1_valid_q <= gnt_valid_d;
         if (gnt_valid_d) begin
            s1_port_q <= gnt_idx_d;
            s1_cmd_q  <= cmd_q[gnt_idx_d];
            s1_a_q    <= op1_q[gnt_idx_d];
            s1_b_q    <= op2_q[gnt_idx_d];
            ptr_q     <= (gnt_idx_d == PW'(PORTS - 1)) ? '0 : gnt_idx_d + 1'b1;
         end
      end
   end

   always_comb begin
      sum_d      = {1'b0, s1_a_q} + {1'b0, s1_b_q};
      res_code_d = 2'd1;
      res_data_d = '0;
      case (s1_cmd_q)
         4'd1: begin
            if (sum_d[WIDTH]) res_code_d = 2'd2;
            else              res_data_d = sum_d[WIDTH-1:0];
         end
         4'd2: begin
            if (s1_b_q > s1_a_q) res_code_d = 2'd2;
            else                 res_data_d = s1_a_q - s1_b_q;
         end
         4'd5:    res_data_d = s1_a_q << s1_b_q[SW-1:0];
         4'd6:    res_data_d = s1_a_q >> s1_b_q[SW-1:0];
         default: res_code_d = 2'd3;
      endcase
   end

   generate
      for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
         logic [3:0]       cmd_w;
         logic [WIDTH-1:0] data_w;
         assign cmd_w  = req_cmd[4*gi +: 4];
         assign data_w = req_data[WIDTH*gi +: WIDTH];

         // busy covers operand-2 capture, pending, in-flight and the response cycle.
         always_ff @(posedge clk) begin
            if (reset) begin
               busy_q[gi]     <= 1'b0;
               wait_op2_q[gi] <= 1'b0;
               pend_q[gi]     <= 1'b0;
               cmd_q[gi]      <= '0;
               op1_q[gi]      <= '0;
               op2_q[gi]      <= '0;
               resp_q[gi]     <= '0;
               data_q[gi]     <= '0;
            end else begin
               if (!busy_q[gi] && cmd_w != 4'd0) begin
                  busy_q[gi]     <= 1'b1;
                  wait_op2_q[gi] <= 1'b1;
                  cmd_q[gi]      <= cmd_w;
                  op1_q[gi]      <= data_w;
               end else if (resp_v[gi]) begin
                  busy_q[gi] <= 1'b0;
               end
               if (wait_op2_q[gi]) begin
                  wait_op2_q[gi] <= 1'b0;
                  op2_q[gi]      <= data_w;
                  pend_q[gi]     <= 1'b1;
               end
               if (gnt_oh_d[gi]) pend_q[gi] <= 1'b0;
               if (s1_valid_q && s1_port_q == PW'(gi)) begin
                  resp_q[gi] <= res_code_d;
                  data_q[gi] <= res_data_d;
               end else begin
                  resp_q[gi] <= '0;
                  data_q[gi] <= '0;
               end
            end
         end

         assign resp_v[gi]                   = (resp_q[gi] != 2'd0);
         assign out_resp[2*gi +: 2]          = reset ? 2'd0 : resp_q[gi];
         assign out_data[WIDTH*gi +: WIDTH]  = reset ? '0 : data_q[gi];
         assign busy[gi]                     = reset ? 1'b0 : busy_q[gi];
      end
   endgenerate

endmodule
